bus_arbiter: RTL and testbench

- Owns the shared memory bus between the CPU and NUM_REQ DMA controllers.
- Each DMA controller raises its bus request (br) and waits for its bus grant (bg).
- The arbiter drains any in-flight CPU memory access, stalls the CPU, grants exactly one DMA requester (round-robin), and returns the bus to the CPU when the requester drops br.
- Sits between the CPU memory port, the DMA controllers and the memory address/data mux, driving that mux's select.

---
 rtl/bus_arb_pkg.sv | 9 +
 rtl/bus_arbiter_rr_picker.sv | 27 ++
 rtl/bus_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state encoding and field widths for the bus arbiter
package bus_arb_pkg;
  localparam int STATE_W = 2;
  localparam int GID_W   = 2;
  localparam logic [STATE_W-1:0] CPU_OWN = 2'd0;
  localparam logic [STATE_W-1:0] DRAIN   = 2'd1;
  localparam logic [STATE_W-1:0] GRANT   = 2'd2;
  localparam logic [STATE_W-1:0] RELEASE = 2'd3;
endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting after the last grant
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last,
  output logic               valid,
  output logic [GID_W-1:0]   winner
);
  // scan (last+1)..(last+NUM_REQ) mod NUM_REQ, first set bit wins
  always_comb begin
    logic found;
    int   idx;
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = GID_W'(idx);
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA bus ownership FSM with round-robin grant; BUS_ARB_TIMEOUT_EN adds a sticky hold-timeout flag
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int HOLD_MAX = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_mem_busy,
  input  logic [NUM_REQ-1:0] br,
  output logic [NUM_REQ-1:0] bg,
  output logic               cpu_stall,
  output logic               bus_sel,
  output logic [GID_W-1:0]   grant_id,
  output logic               timeout_err
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [NUM_REQ-1:0] bg_q, bg_d;
  logic               cpu_stall_q, cpu_stall_d;
  logic               bus_sel_q, bus_sel_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [GID_W-1:0]   rr_last_q, rr_last_d;
  logic               win_valid;
  logic [GID_W-1:0]   win_id;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (br),
    .last   (rr_last_q),
    .valid  (win_valid),
    .winner (win_id)
  );

  // next-state and registered-output logic; a grant loads all grant outputs on the same edge
  always_comb begin
    logic do_grant;
    state_d     = state_q;
    bg_d        = bg_q;
    cpu_stall_d = cpu_stall_q;
    bus_sel_d   = bus_sel_q;
    grant_id_d  = grant_id_q;
    rr_last_d   = rr_last_q;
    do_grant    = 1'b0;
    case (state_q)
      CPU_OWN: begin
        bg_d        = '0;
        bus_sel_d   = 1'b0;
        cpu_stall_d = 1'b0;
        if (win_valid && !cpu_mem_busy) do_grant = 1'b1;
        else if (win_valid) begin
          state_d     = DRAIN;
          cpu_stall_d = 1'b1;
        end
      end
      DRAIN: begin
        cpu_stall_d = 1'b1;
        if (!win_valid) begin
          state_d     = CPU_OWN;
          cpu_stall_d = 1'b0;
        end else if (!cpu_mem_busy) do_grant = 1'b1;
      end
      GRANT: begin
        if (!(|(br & bg_q))) begin
          state_d   = RELEASE;
          bg_d      = '0;
          bus_sel_d = 1'b0;
        end
      end
      default: begin
        state_d     = CPU_OWN;
        bg_d        = '0;
        bus_sel_d   = 1'b0;
        cpu_stall_d = 1'b0;
      end
    endcase
    if (do_grant) begin
      state_d     = GRANT;
      bg_d        = NUM_REQ'(1) << win_id;
      bus_sel_d   = 1'b1;
      cpu_stall_d = 1'b1;
      grant_id_d  = win_id;
      rr_last_d   = win_id;
    end
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= CPU_OWN;
      bg_q        <= '0;
      cpu_stall_q <= 1'b0;
      bus_sel_q   <= 1'b0;
      grant_id_q  <= '0;
      rr_last_q   <= GID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      bg_q        <= bg_d;
      cpu_stall_q <= cpu_stall_d;
      bus_sel_q   <= bus_sel_d;
      grant_id_q  <= grant_id_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign bg        = bg_q;
  assign cpu_stall = cpu_stall_q;
  assign bus_sel   = bus_sel_q;
  assign grant_id  = grant_id_q;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // count completed GRANT cycles, cleared on every GRANT entry; the flag is sticky and never revokes the grant
  always_comb begin
    hold_cnt_d    = hold_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q != GRANT && state_d == GRANT) hold_cnt_d = '0;
    else if (state_q == GRANT && hold_cnt_q != CNT_W'(HOLD_MAX)) hold_cnt_d = hold_cnt_q + 1'b1;
    if (state_q == GRANT && hold_cnt_d == CNT_W'(HOLD_MAX)) timeout_err_d = 1'b1;
  end

  // timeout counter and flag registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector self-checking bench for bus_arbiter (NUM_REQ=2, HOLD_MAX=8)
module tb_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_mem_busy;
  logic [1:0] br;
  logic [1:0] bg;
  logic       cpu_stall;
  logic       bus_sel;
  logic [1:0] grant_id;
  logic       timeout_err;
  int         n_chk = 0;
  int         n_pass = 0;

  bus_arbiter #(.NUM_REQ(2), .HOLD_MAX(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_mem_busy (cpu_mem_busy),
    .br           (br),
    .bg           (bg),
    .cpu_stall    (cpu_stall),
    .bus_sel      (bus_sel),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_sel", 8'(bus_sel), 8'(|bg));
    chk("inv_onehot", 8'($countones(bg) <= 1), 8'd1);
    if (bus_sel) chk("inv_stall", 8'(cpu_stall), 8'd1);
  endtask

  task automatic outs(input string tag, input logic [1:0] e_bg, input logic e_stall, input logic [1:0] e_gid);
    chk({tag, "_bg"}, 8'(bg), 8'(e_bg));
    chk({tag, "_sel"}, 8'(bus_sel), 8'(|e_bg));
    chk({tag, "_stall"}, 8'(cpu_stall), 8'(e_stall));
    chk({tag, "_gid"}, 8'(grant_id), 8'(e_gid));
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_mem_busy = 1'b0;
    br = 2'b00;
    tick();
    tick();
    outs("reset", 2'b00, 1'b0, 2'd0);
    chk("reset_err", 8'(timeout_err), 8'd0);
    reset_n = 1'b1;
    tick();
    outs("idle", 2'b00, 1'b0, 2'd0);

    br = 2'b01;
    tick();
    outs("single_grant", 2'b01, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) tick();
    outs("single_hold", 2'b01, 1'b1, 2'd0);
    br = 2'b00;
    tick();
    outs("single_release", 2'b00, 1'b1, 2'd0);
    tick();
    outs("single_cpu", 2'b00, 1'b0, 2'd0);

    cpu_mem_busy = 1'b1;
    br = 2'b01;
    tick();
    outs("drain_enter", 2'b00, 1'b1, 2'd0);
    tick();
    tick();
    outs("drain_wait", 2'b00, 1'b1, 2'd0);
    cpu_mem_busy = 1'b0;
    tick();
    outs("drain_grant", 2'b01, 1'b1, 2'd0);
    br = 2'b00;
    tick();
    tick();
    outs("drain_done", 2'b00, 1'b0, 2'd0);

    cpu_mem_busy = 1'b1;
    br = 2'b01;
    tick();
    outs("wd_drain", 2'b00, 1'b1, 2'd0);
    br = 2'b00;
    tick();
    outs("wd_back", 2'b00, 1'b0, 2'd0);
    cpu_mem_busy = 1'b0;
    tick();
    outs("wd_idle", 2'b00, 1'b0, 2'd0);

    br = 2'b10;
    tick();
    outs("rst_pre", 2'b10, 1'b1, 2'd1);
    reset_n = 1'b0;
    tick();
    outs("rst_mid", 2'b00, 1'b0, 2'd0);
    reset_n = 1'b1;
    br = 2'b00;
    tick();
    outs("rst_after", 2'b00, 1'b0, 2'd0);

    br = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] e_id;
      logic [1:0] e_bg;
      e_id = 2'(g % 2);
      e_bg = 2'b01 << e_id;
      tick();
      outs($sformatf("rr%0d_grant", g), e_bg, 1'b1, e_id);
      tick();
      tick();
      tick();
      outs($sformatf("rr%0d_hold", g), e_bg, 1'b1, e_id);
      br = ~e_bg;
      tick();
      outs($sformatf("rr%0d_rel", g), 2'b00, 1'b1, e_id);
      br = 2'b11;
      tick();
      outs($sformatf("rr%0d_cpu", g), 2'b00, 1'b0, e_id);
    end
    br = 2'b00;
    tick();
    tick();

`ifdef BUS_ARB_TIMEOUT_EN
    br = 2'b01;
    tick();
    outs("to_grant", 2'b01, 1'b1, 2'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("to_before", 8'(timeout_err), 8'd0);
    tick();
    chk("to_set", 8'(timeout_err), 8'd1);
    chk("to_bg", 8'(bg), 8'h01);
    tick();
    tick();
    chk("to_still_bg", 8'(bg), 8'h01);
    br = 2'b00;
    tick();
    tick();
    chk("to_sticky", 8'(timeout_err), 8'd1);
    outs("to_released", 2'b00, 1'b0, 2'd0);
`else
    br = 2'b01;
    for (int i = 0; i < 12; i++) tick();
    chk("no_to_err", 8'(timeout_err), 8'd0);
    chk("no_to_bg", 8'(bg), 8'h01);
    br = 2'b00;
    tick();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
